// File: rtl/cdc_wave_pkg.sv
// rtl/cdc_wave_pkg.sv - shared constants and parser state for the USB waveform dispatcher
package cdc_wave_pkg;

    localparam int DEF_MAX_SAMPLES = 4096;
    localparam int DEF_ADDR_W      = 12;
    localparam int DEF_FRAC_BITS   = 20;
    localparam int SAMPLE_W        = 14;

    localparam logic [7:0] OP_CUSTOM = 8'hFC;
    localparam logic [7:0] OP_DDS    = 8'hFD;
    localparam logic [7:0] HDR_SYNC0 = 8'hAA;
    localparam logic [7:0] HDR_SYNC1 = 8'h55;

    // Offset-binary RAM samples become two's complement by subtracting mid-scale
    localparam logic [SAMPLE_W-1:0] DAC_OFFSET = 14'd8192;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_CMD,
        ST_LEN_H,
        ST_LEN_L,
        ST_PAYLOAD,
        ST_CHK
    } parse_state_t;

endpackage

// File: rtl/cdc_wave_dispatch_player.sv
// rtl/cdc_wave_dispatch_player.sv - waveform RAM, fractional playback accumulator and DAC output register
module wave_ram_player
    import cdc_wave_pkg::*;
#(
    parameter int MAX_SAMPLES = DEF_MAX_SAMPLES,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int FRAC_BITS   = DEF_FRAC_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                load,
    input  logic                load_active,
    input  logic                stop,
    input  logic [ADDR_W:0]     count,
    input  logic [31:0]         rate,
    input  logic [SAMPLE_W-1:0] dds_sample,
    output logic [SAMPLE_W-1:0] dac_data,
    output logic                active,
    output logic [ADDR_W-1:0]   rd_addr
);

    localparam int ACC_W = FRAC_BITS + ADDR_W + 1;

    logic [SAMPLE_W-1:0] mem [MAX_SAMPLES];
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [ACC_W-1:0]    acc_next;
    logic [ACC_W-1:0]    limit;
    logic [ADDR_W:0]     count_q;
    logic [31:0]         rate_q;
    logic [SAMPLE_W-1:0] ram_q;
    logic [SAMPLE_W-1:0] dds_q;
    logic                sel_q;

    assign rd_addr = acc[FRAC_BITS +: ADDR_W];

    // Single conditional subtract keeps the fractional phase across the wrap
    always_comb begin
        limit    = {count_q, {FRAC_BITS{1'b0}}};
        acc_sum  = acc + ACC_W'(rate_q);
        acc_next = (acc_sum >= limit) ? (acc_sum - limit) : acc_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            count_q <= '0;
            rate_q  <= '0;
            active  <= 1'b0;
        end else if (load) begin
            acc     <= '0;
            count_q <= count;
            rate_q  <= rate;
            active  <= load_active;
        end else if (stop) begin
            active  <= 1'b0;
        end else if (active) begin
            acc     <= acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // sel_q delays the source select so both paths see the same two-cycle latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_q    <= '0;
            dds_q    <= '0;
            sel_q    <= 1'b0;
            dac_data <= '0;
        end else begin
            ram_q    <= mem[rd_addr];
            dds_q    <= dds_sample;
            sel_q    <= active;
            dac_data <= sel_q ? (ram_q - DAC_OFFSET) : dds_q;
        end
    end

endmodule

// File: rtl/cdc_wave_dispatch.sv
// rtl/cdc_wave_dispatch.sv - USB framed-command parser with waveform upload and DDS configuration
module cdc_wave_dispatch
    import cdc_wave_pkg::*;
#(
    parameter int         MAX_SAMPLES = DEF_MAX_SAMPLES,
    parameter int         ADDR_W      = DEF_ADDR_W,
    parameter int         FRAC_BITS   = DEF_FRAC_BITS,
    parameter logic [7:0] CMD_CUSTOM  = OP_CUSTOM,
    parameter logic [7:0] CMD_DDS     = OP_DDS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          usb_data_in,
    input  logic                usb_data_valid_in,
    input  logic [SAMPLE_W-1:0] dds_sample_in,
    output logic [SAMPLE_W-1:0] dac_data,
    output logic [1:0]          dds_wave_type,
    output logic [31:0]         dds_freq_word,
    output logic [31:0]         dds_phase_word,
    output logic                dds_cfg_valid,
    output logic                custom_wave_active,
    output logic [ADDR_W-1:0]   rd_addr_dbg,
    output logic                led_out
);

    localparam logic [15:0] MAX_CNT = 16'(MAX_SAMPLES);

    parse_state_t state;
    parse_state_t state_next;

    logic [7:0]          cmd_q;
    logic [15:0]         len_q;
    logic [15:0]         idx_q;
    logic [7:0]          sum_q;
    logic                ctrl_play;
    logic [15:0]         scount_q;
    logic [31:0]         srate_q;
    logic [7:0]          lo_q;
    logic [1:0]          dtype_q;
    logic [31:0]         dfreq_q;
    logic [31:0]         dphase_q;

    logic [15:0]         sample_off;
    logic [14:0]         sample_k;
    logic                custom_ok;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [SAMPLE_W-1:0] wr_data;
    logic                play_load;
    logic                play_stop;
    logic                cfg_load;

    assign sample_off = idx_q - 16'd7;
    assign sample_k   = sample_off[15:1];
    assign custom_ok  = (scount_q != 16'd0) && (scount_q <= MAX_CNT)
                     && ({1'b0, len_q} == (17'd7 + {scount_q, 1'b0}));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (usb_data_valid_in) begin
            case (state)
                ST_IDLE:    if (usb_data_in == HDR_SYNC0) state_next = ST_SYNC;
                ST_SYNC: begin
                    if (usb_data_in == HDR_SYNC1)      state_next = ST_CMD;
                    else if (usb_data_in == HDR_SYNC0) state_next = ST_SYNC;
                    else                               state_next = ST_IDLE;
                end
                ST_CMD:     state_next = ST_LEN_H;
                ST_LEN_H:   state_next = ST_LEN_L;
                ST_LEN_L:   state_next = ({len_q[15:8], usb_data_in} == 16'd0) ? ST_CHK : ST_PAYLOAD;
                ST_PAYLOAD: if (idx_q == len_q - 16'd1) state_next = ST_CHK;
                ST_CHK:     state_next = ST_IDLE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        play_load = 1'b0;
        play_stop = 1'b0;
        cfg_load  = 1'b0;
        if (usb_data_valid_in && state == ST_PAYLOAD && cmd_q == CMD_CUSTOM) begin
            if (idx_q == 16'd0) begin
                play_stop = 1'b1;
            end
            // Second byte of each sample completes the RAM word
            if (idx_q >= 16'd7 && sample_off[0] && ({1'b0, sample_k} < MAX_CNT)) begin
                wr_en   = 1'b1;
                wr_addr = sample_k[ADDR_W-1:0];
                wr_data = {usb_data_in[5:0], lo_q};
            end
        end
        if (usb_data_valid_in && state == ST_CHK && sum_q == usb_data_in) begin
            if (cmd_q == CMD_CUSTOM && custom_ok) begin
                play_load = 1'b1;
            end
            if (cmd_q == CMD_DDS && len_q == 16'd9) begin
                cfg_load  = 1'b1;
                play_stop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            ctrl_play <= 1'b0;
            scount_q  <= '0;
            srate_q   <= '0;
            lo_q      <= '0;
            dtype_q   <= '0;
            dfreq_q   <= '0;
            dphase_q  <= '0;
        end else if (usb_data_valid_in) begin
            case (state)
                ST_CMD: begin
                    cmd_q     <= usb_data_in;
                    sum_q     <= usb_data_in;
                    ctrl_play <= 1'b0;
                    scount_q  <= '0;
                    srate_q   <= '0;
                end
                ST_LEN_H: begin
                    len_q[15:8] <= usb_data_in;
                    sum_q       <= sum_q + usb_data_in;
                end
                ST_LEN_L: begin
                    len_q[7:0] <= usb_data_in;
                    sum_q      <= sum_q + usb_data_in;
                    idx_q      <= '0;
                end
                ST_PAYLOAD: begin
                    sum_q <= sum_q + usb_data_in;
                    idx_q <= idx_q + 16'd1;
                    if (cmd_q == CMD_CUSTOM) begin
                        if (idx_q == 16'd0)                          ctrl_play      <= usb_data_in[2];
                        else if (idx_q == 16'd1)                     scount_q[15:8] <= usb_data_in;
                        else if (idx_q == 16'd2)                     scount_q[7:0]  <= usb_data_in;
                        else if (idx_q <= 16'd6)                     srate_q        <= {srate_q[23:0], usb_data_in};
                        else if (!sample_off[0])                     lo_q           <= usb_data_in;
                    end else if (cmd_q == CMD_DDS) begin
                        if (idx_q == 16'd0)                          dtype_q  <= usb_data_in[1:0];
                        else if (idx_q <= 16'd4)                     dfreq_q  <= {dfreq_q[23:0], usb_data_in};
                        else if (idx_q <= 16'd8)                     dphase_q <= {dphase_q[23:0], usb_data_in};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dds_wave_type  <= '0;
            dds_freq_word  <= '0;
            dds_phase_word <= '0;
            dds_cfg_valid  <= 1'b0;
        end else begin
            dds_cfg_valid <= cfg_load;
            if (cfg_load) begin
                dds_wave_type  <= dtype_q;
                dds_freq_word  <= dfreq_q;
                dds_phase_word <= dphase_q;
            end
        end
    end

    wave_ram_player #(
        .MAX_SAMPLES (MAX_SAMPLES),
        .ADDR_W      (ADDR_W),
        .FRAC_BITS   (FRAC_BITS)
    ) u_player (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .load        (play_load),
        .load_active (ctrl_play),
        .stop        (play_stop),
        .count       (scount_q[ADDR_W:0]),
        .rate        (srate_q),
        .dds_sample  (dds_sample_in),
        .dac_data    (dac_data),
        .active      (custom_wave_active),
        .rd_addr     (rd_addr_dbg)
    );

    assign led_out = custom_wave_active;

endmodule

// File: tb/tb_cdc_wave_dispatch.sv
// tb/tb_cdc_wave_dispatch.sv - self-checking bench for cdc_wave_dispatch
module tb_cdc_wave_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  usb_data_in;
    logic        usb_data_valid_in;
    logic [13:0] dds_sample_in;
    logic [13:0] dac_data;
    logic [1:0]  dds_wave_type;
    logic [31:0] dds_freq_word;
    logic [31:0] dds_phase_word;
    logic        dds_cfg_valid;
    logic        custom_wave_active;
    logic [11:0] rd_addr_dbg;
    logic        led_out;

    always #5 clk = ~clk;

    cdc_wave_dispatch dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .usb_data_in        (usb_data_in),
        .usb_data_valid_in  (usb_data_valid_in),
        .dds_sample_in      (dds_sample_in),
        .dac_data           (dac_data),
        .dds_wave_type      (dds_wave_type),
        .dds_freq_word      (dds_freq_word),
        .dds_phase_word     (dds_phase_word),
        .dds_cfg_valid      (dds_cfg_valid),
        .custom_wave_active (custom_wave_active),
        .rd_addr_dbg        (rd_addr_dbg),
        .led_out            (led_out)
    );

    typedef struct {
        int          cnt;
        int          len_adj;
        logic [31:0] rate;
        logic [7:0]  ctrl;
        logic [7:0]  chk_adj;
        bit          ramp;
        bit          pre;
        bit          exp_act;
        int          cycles;
    } vec_t;

    vec_t        vt [11];
    int          tests = 0;
    int          fails = 0;
    int          pulses = 0;
    logic [13:0] ram_m [0:4095];
    logic [7:0]  fq [$];
    logic [7:0]  csum;

    always @(posedge clk) if (dds_cfg_valid === 1'b1) pulses <= pulses + 1;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps && $urandom_range(0, 3) == 0) tick();
        usb_data_in       = b;
        usb_data_valid_in = 1'b1;
        tick();
        usb_data_valid_in = 1'b0;
    endtask

    task automatic send_q(input int n, input bit gaps);
        for (int i = 0; i < n; i++) send_byte(fq[i], gaps);
    endtask

    task automatic addb(input logic [7:0] b);
        fq.push_back(b);
        csum = csum + b;
    endtask

    task automatic build_custom(input int cnt, input int len_adj, input logic [31:0] rate,
                                input logic [7:0] ctrl, input logic [7:0] chk_adj,
                                input bit ramp, input bit pre);
        int          len;
        logic [13:0] v;
        v = '0;
        fq.delete();
        len = 7 + 2 * cnt + len_adj;
        if (pre) begin
            fq.push_back(8'hAA);
            fq.push_back(8'h12);
            fq.push_back(8'hAA);
        end
        fq.push_back(8'hAA);
        fq.push_back(8'h55);
        csum = 8'h00;
        addb(8'hFC);
        addb(len[15:8]);
        addb(len[7:0]);
        addb(ctrl);
        addb(cnt[15:8]);
        addb(cnt[7:0]);
        addb(rate[31:24]);
        addb(rate[23:16]);
        addb(rate[15:8]);
        addb(rate[7:0]);
        for (int i = 0; i < len - 7; i++) begin
            if (i % 2 == 0) begin
                v = ramp ? 14'((i / 2) * 64) : 14'($urandom);
                addb(v[7:0]);
            end else begin
                addb({2'b00, v[13:8]});
                if (i / 2 < 4096) ram_m[i / 2] = v;
            end
        end
        fq.push_back(csum + chk_adj);
    endtask

    task automatic build_dds(input int len, input logic [1:0] t, input logic [31:0] f, input logic [31:0] p);
        logic [7:0] pl [9];
        pl = '{{6'b0, t}, f[31:24], f[23:16], f[15:8], f[7:0], p[31:24], p[23:16], p[15:8], p[7:0]};
        fq.delete();
        fq.push_back(8'hAA);
        fq.push_back(8'h55);
        csum = 8'h00;
        addb(8'hFD);
        addb(len[15:8]);
        addb(len[7:0]);
        for (int i = 0; i < len; i++) addb(i < 9 ? pl[i] : 8'h00);
        fq.push_back(csum);
    endtask

    // Reference: phase after j cycles is (j*rate) mod (count<<20); dac trails the address by two cycles
    task automatic check_play(input int cnt, input logic [31:0] rate, input int cycles, input string nm);
        longint      lim;
        longint      r;
        int          a;
        int          ah [$];
        logic [13:0] e;
        lim = longint'(cnt) << 20;
        r   = rate;
        for (int j = 0; j < cycles; j++) begin
            a = int'(((longint'(j) * r) % lim) >> 20);
            ah.push_back(a);
            chk({nm, " addr"}, rd_addr_dbg, a);
            chk({nm, " active"}, custom_wave_active, 1);
            if (j >= 2) begin
                e = ram_m[ah[j - 2]] - 14'd8192;
                chk({nm, " dac"}, dac_data, e);
            end
            tick();
        end
    endtask

    task automatic check_dds(input int n, input string nm);
        logic [13:0] h [$];
        for (int i = 0; i < n; i++) begin
            if (i >= 2) chk({nm, " dds_path"}, dac_data, h[i - 2]);
            h.push_back(14'($urandom));
            dds_sample_in = h[i];
            tick();
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, " dac"}, dac_data, 0);
        chk({nm, " active"}, custom_wave_active, 0);
        chk({nm, " led"}, led_out, 0);
        chk({nm, " addr"}, rd_addr_dbg, 0);
        chk({nm, " type"}, dds_wave_type, 0);
        chk({nm, " freq"}, dds_freq_word, 0);
        chk({nm, " phase"}, dds_phase_word, 0);
        chk({nm, " cfg_valid"}, dds_cfg_valid, 0);
    endtask

    int          seq4 [9];
    int          p0;
    int          rc;
    logic [31:0] rr;

    initial begin
        rst_n             = 1'b0;
        usb_data_in       = 8'h00;
        usb_data_valid_in = 1'b0;
        dds_sample_in     = 14'h0000;
        seq4 = '{0, 1, 3, 0, 2, 3, 1, 2, 0};

        vt[0]  = '{256, 0, 32'h0010_0000, 8'h04, 8'h00, 1'b1, 1'b0, 1'b1, 600};
        vt[1]  = '{256, 0, 32'h0010_0000, 8'h04, 8'h01, 1'b1, 1'b0, 1'b0, 0};
        vt[2]  = '{16,  0, 32'h0008_0000, 8'h04, 8'h00, 1'b0, 1'b0, 1'b1, 40};
        vt[3]  = '{3,   0, 32'h0018_0000, 8'h04, 8'h00, 1'b0, 1'b0, 1'b1, 30};
        vt[4]  = '{20,  0, 32'h0003_5000, 8'h04, 8'h00, 1'b0, 1'b1, 1'b1, 50};
        vt[5]  = '{0,   0, 32'h0010_0000, 8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 0};
        vt[6]  = '{8,   2, 32'h0010_0000, 8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 0};
        vt[7]  = '{8,  -1, 32'h0010_0000, 8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 0};
        vt[8]  = '{10,  0, 32'h0010_0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0};
        vt[9]  = '{4096, 0, 32'h7FF0_0000, 8'h04, 8'h00, 1'b0, 1'b0, 1'b1, 60};
        vt[10] = '{4097, 0, 32'h0010_0000, 8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 0};

        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            build_custom(vt[i].cnt, vt[i].len_adj, vt[i].rate, vt[i].ctrl, vt[i].chk_adj, vt[i].ramp, vt[i].pre);
            send_q(fq.size(), 1'b1);
            chk($sformatf("vec%0d active", i), custom_wave_active, vt[i].exp_act);
            chk($sformatf("vec%0d led", i), led_out, vt[i].exp_act);
            if (vt[i].exp_act) check_play(vt[i].cnt, vt[i].rate, vt[i].cycles, $sformatf("vec%0d", i));
            else               check_dds(8, $sformatf("vec%0d", i));
        end

        // Fraction carried through the wrap: 1.5 samples/cycle over 4 samples
        build_custom(4, 0, 32'h0018_0000, 8'h04, 8'h00, 1'b0, 1'b0);
        send_q(fq.size(), 1'b1);
        for (int j = 0; j < 9; j++) begin
            chk($sformatf("seq4[%0d]", j), rd_addr_dbg, seq4[j]);
            tick();
        end

        p0 = pulses;
        build_dds(9, 2'd0, 32'h0100_0000, 32'h0000_0000);
        send_q(fq.size(), 1'b0);
        chk("dds cfg_valid hi", dds_cfg_valid, 1);
        chk("dds freq", dds_freq_word, 32'h0100_0000);
        chk("dds phase", dds_phase_word, 0);
        chk("dds type", dds_wave_type, 0);
        chk("dds active", custom_wave_active, 0);
        chk("dds led", led_out, 0);
        tick();
        chk("dds cfg_valid lo", dds_cfg_valid, 0);
        tick();
        chk("dds pulse count", pulses - p0, 1);
        check_dds(10, "after_dds");

        p0 = pulses;
        build_dds(8, 2'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        send_q(fq.size(), 1'b1);
        tick();
        tick();
        chk("bad dds pulses", pulses - p0, 0);
        chk("bad dds freq", dds_freq_word, 32'h0100_0000);
        chk("bad dds type", dds_wave_type, 0);

        dds_sample_in = 14'h0123;
        tick();
        tick();
        chk("dds 0123", dac_data, 14'h0123);

        for (int k = 0; k < 4; k++) begin
            rc = $urandom_range(2, 64);
            rr = $urandom_range(1, rc * 1048576 - 1);
            build_custom(rc, 0, rr, 8'h04, 8'h00, 1'b0, 1'b0);
            send_q(fq.size(), 1'b1);
            chk($sformatf("rnd%0d active", k), custom_wave_active, 1);
            check_play(rc, rr, 80, $sformatf("rnd%0d", k));
        end

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_zero("rst_play");
        tick();

        build_custom(32, 0, 32'h0010_0000, 8'h04, 8'h00, 1'b1, 1'b0);
        send_q(20, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_zero("rst_payload");
        tick();
        send_q(fq.size(), 1'b1);
        chk("post_rst active", custom_wave_active, 1);
        check_play(32, 32'h0010_0000, 70, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
